// File: rtl/unidade_controle_genius_pkg.sv
// Shared definitions for the memory-game control unit: state codes (also
// used by db_estado decoding and hex-display logic) and the Moore output
// bundle with its per-state decode.
package unidade_controle_genius_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        INICIO_RODADA  = 4'd2,
        MOSTRA_ACESO   = 4'd3,
        MOSTRA_APAGADO = 4'd4,
        MOSTRA_PROX    = 4'd5,
        FIM_MOSTRA     = 4'd6,
        ESPERA         = 4'd7,
        REGISTRA       = 4'd8,
        COMPARA        = 4'd9,
        PROX_JOGADA    = 4'd10,
        PROX_RODADA    = 4'd11,
        FIM_ACERTO     = 4'd12,
        FIM_ERRO       = 4'd13,
        FIM_TIMEOUT    = 4'd14
    } estado_t;

    typedef struct packed {
        logic zera_endereco;
        logic conta_endereco;
        logic zera_limite;
        logic conta_limite;
        logic zeraR;
        logic registrarR;
        logic zera_s_timeout;
        logic enable_timeout;
        logic zera_modo;
        logic registra_modo;
        logic conf_leds;
        logic pronto;
        logic ganhou;
        logic perdeu;
        logic db_timeout;
    } saidas_t;

    // Output decode of a state; LEDs show memory data only in MOSTRA_ACESO.
    function automatic saidas_t saidas_de(estado_t e);
        saidas_t s;
        s = '0;
        s.conf_leds = (e != MOSTRA_ACESO);
        case (e)
            INICIAL: s.zera_modo = 1'b1;
            PREPARA: begin
                s.zera_endereco  = 1'b1;
                s.zera_limite    = 1'b1;
                s.zeraR          = 1'b1;
                s.zera_s_timeout = 1'b1;
                s.registra_modo  = 1'b1;
            end
            INICIO_RODADA: begin
                s.zera_endereco = 1'b1;
                s.zeraR         = 1'b1;
            end
            MOSTRA_PROX: s.conta_endereco = 1'b1;
            FIM_MOSTRA: begin
                s.zera_endereco  = 1'b1;
                s.zera_s_timeout = 1'b1;
            end
            ESPERA: s.enable_timeout = 1'b1;
            REGISTRA: begin
                s.registrarR     = 1'b1;
                s.zera_s_timeout = 1'b1;
            end
            PROX_JOGADA: s.conta_endereco = 1'b1;
            PROX_RODADA: begin
                s.conta_limite  = 1'b1;
                s.zera_endereco = 1'b1;
            end
            FIM_ACERTO: begin
                s.pronto = 1'b1;
                s.ganhou = 1'b1;
            end
            FIM_ERRO: begin
                s.pronto = 1'b1;
                s.perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                s.pronto     = 1'b1;
                s.perdeu     = 1'b1;
                s.db_timeout = 1'b1;
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/unidade_controle_genius_contador_m.sv
// Modulo-M up-counter with async active-low clear, synchronous clear and
// count enable. Used as the playback display timer.
module contador_m #(
    parameter int M = 1000,
    parameter int N = 10
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_zera_s,
    input  logic         i_conta,
    output logic [N-1:0] o_q
);

    localparam logic [N-1:0] C_MAX = N'(M - 1);

    logic [N-1:0] r_q;

    // Count with wrap at M-1; synchronous clear has priority over counting.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_q <= '0;
        end else if (i_zera_s) begin
            r_q <= '0;
        end else if (i_conta) begin
            r_q <= (r_q == C_MAX) ? '0 : r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/unidade_controle_genius.sv
// Moore control unit for the memory game: plays back the stored sequence up
// to the current round limit, collects and checks one press per position,
// and ends in win / error / timeout. Outputs are registered alongside the
// state so they are clean functions of the state register.
module unidade_controle_genius
    import unidade_controle_genius_pkg::*;
#(
    parameter int T_ACESO   = 1000,
    parameter int T_APAGADO = 500,
    parameter int TIMER_N   = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       igual,
    input  logic       enderecoIgualLimite,
    input  logic       fim_jogo,
    input  logic       jogada_feita,
    input  logic       timeout,
    output logic       zera_endereco,
    output logic       conta_endereco,
    output logic       zera_limite,
    output logic       conta_limite,
    output logic       zeraR,
    output logic       registrarR,
    output logic       zera_s_timeout,
    output logic       enable_timeout,
    output logic       zera_modo,
    output logic       registra_modo,
    output logic       conf_leds,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    localparam int M_TIMER = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam logic [TIMER_N-1:0] C_FIM_ACESO   = TIMER_N'(T_ACESO - 1);
    localparam logic [TIMER_N-1:0] C_FIM_APAGADO = TIMER_N'(T_APAGADO - 1);

    estado_t              r_estado;
    saidas_t              r_saidas;
    estado_t              w_prox;
    logic [TIMER_N-1:0]   w_q;
    logic                 w_fim_aceso;
    logic                 w_fim_apagado;
    logic                 w_mostrando;
    logic                 w_zera_timer;

    // Timer runs only inside the two MOSTRA states and is cleared on each
    // interval end, so it reads 0 on the first cycle of the next MOSTRA state.
    assign w_mostrando   = (r_estado == MOSTRA_ACESO) || (r_estado == MOSTRA_APAGADO);
    assign w_fim_aceso   = (r_estado == MOSTRA_ACESO)   && (w_q == C_FIM_ACESO);
    assign w_fim_apagado = (r_estado == MOSTRA_APAGADO) && (w_q == C_FIM_APAGADO);
    assign w_zera_timer  = !w_mostrando || w_fim_aceso || w_fim_apagado;

    contador_m #(
        .M (M_TIMER),
        .N (TIMER_N)
    ) u_timer (
        .i_clock  (clock),
        .i_reset  (reset),
        .i_zera_s (w_zera_timer),
        .i_conta  (!w_zera_timer),
        .o_q      (w_q)
    );

    // Next-state selection for the FSM.
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            INICIAL:        if (jogar) w_prox = PREPARA;
            PREPARA:        w_prox = INICIO_RODADA;
            INICIO_RODADA:  w_prox = MOSTRA_ACESO;
            MOSTRA_ACESO:   if (w_fim_aceso) w_prox = MOSTRA_APAGADO;
            MOSTRA_APAGADO: if (w_fim_apagado)
                                w_prox = enderecoIgualLimite ? FIM_MOSTRA : MOSTRA_PROX;
            MOSTRA_PROX:    w_prox = MOSTRA_ACESO;
            FIM_MOSTRA:     w_prox = ESPERA;
            ESPERA: begin
                if (timeout)           w_prox = FIM_TIMEOUT;
                else if (jogada_feita) w_prox = REGISTRA;
            end
            REGISTRA:       w_prox = COMPARA;
            COMPARA: begin
                if (!igual)                    w_prox = FIM_ERRO;
                else if (!enderecoIgualLimite) w_prox = PROX_JOGADA;
                else if (fim_jogo)             w_prox = FIM_ACERTO;
                else                           w_prox = PROX_RODADA;
            end
            PROX_JOGADA:    w_prox = ESPERA;
            PROX_RODADA:    w_prox = INICIO_RODADA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                            if (jogar) w_prox = PREPARA;
            default:        w_prox = INICIAL;
        endcase
    end

    // State register with outputs decoded from the next state, so both update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
            r_saidas <= saidas_de(INICIAL);
        end else begin
            r_estado <= w_prox;
            r_saidas <= saidas_de(w_prox);
        end
    end

    assign zera_endereco  = r_saidas.zera_endereco;
    assign conta_endereco = r_saidas.conta_endereco;
    assign zera_limite    = r_saidas.zera_limite;
    assign conta_limite   = r_saidas.conta_limite;
    assign zeraR          = r_saidas.zeraR;
    assign registrarR     = r_saidas.registrarR;
    assign zera_s_timeout = r_saidas.zera_s_timeout;
    assign enable_timeout = r_saidas.enable_timeout;
    assign zera_modo      = r_saidas.zera_modo;
    assign registra_modo  = r_saidas.registra_modo;
    assign conf_leds      = r_saidas.conf_leds;
    assign pronto         = r_saidas.pronto;
    assign ganhou         = r_saidas.ganhou;
    assign perdeu         = r_saidas.perdeu;
    assign db_timeout     = r_saidas.db_timeout;
    assign db_estado      = r_estado;

endmodule

// File: tb/tb_unidade_controle_genius.sv
// Bench for unidade_controle_genius: a dwell-counting game model checked
// against the DUT every cycle, plus directed literal checks of the sequence.
module tb_unidade_controle_genius;

    localparam int TA = 4;
    localparam int TP = 2;

    logic clock, reset, jogar, igual, enderecoIgualLimite, fim_jogo, jogada_feita, timeout;
    logic zera_endereco, conta_endereco, zera_limite, conta_limite, zeraR, registrarR;
    logic zera_s_timeout, enable_timeout, zera_modo, registra_modo, conf_leds;
    logic pronto, ganhou, perdeu, db_timeout;
    logic [3:0] db_estado;

    int tests = 0;
    int fails = 0;
    int m_st  = 0;
    int m_cnt = 0;
    int ce_cnt = 0;

    unidade_controle_genius #(.T_ACESO(TA), .T_APAGADO(TP), .TIMER_N(10)) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .igual(igual),
        .enderecoIgualLimite(enderecoIgualLimite), .fim_jogo(fim_jogo),
        .jogada_feita(jogada_feita), .timeout(timeout),
        .zera_endereco(zera_endereco), .conta_endereco(conta_endereco),
        .zera_limite(zera_limite), .conta_limite(conta_limite),
        .zeraR(zeraR), .registrarR(registrarR),
        .zera_s_timeout(zera_s_timeout), .enable_timeout(enable_timeout),
        .zera_modo(zera_modo), .registra_modo(registra_modo),
        .conf_leds(conf_leds), .pronto(pronto), .ganhou(ganhou),
        .perdeu(perdeu), .db_timeout(db_timeout), .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [14:0] w_dut;
    assign w_dut = {zera_endereco, conta_endereco, zera_limite, conta_limite, zeraR,
                    registrarR, zera_s_timeout, enable_timeout, zera_modo, registra_modo,
                    conf_leds, pronto, ganhou, perdeu, db_timeout};

    // Output list per state code, bit order as w_dut.
    function automatic logic [14:0] exp_out(int s);
        logic [14:0] v;
        v = '0;
        v[4] = (s != 3);
        case (s)
            0:  v[6] = 1'b1;
            1:  begin v[14] = 1'b1; v[12] = 1'b1; v[10] = 1'b1; v[8] = 1'b1; v[5] = 1'b1; end
            2:  begin v[14] = 1'b1; v[10] = 1'b1; end
            5:  v[13] = 1'b1;
            6:  begin v[14] = 1'b1; v[8] = 1'b1; end
            7:  v[7] = 1'b1;
            8:  begin v[9] = 1'b1; v[8] = 1'b1; end
            10: v[13] = 1'b1;
            11: begin v[11] = 1'b1; v[14] = 1'b1; end
            12: begin v[3] = 1'b1; v[2] = 1'b1; end
            13: begin v[3] = 1'b1; v[1] = 1'b1; end
            14: begin v[3] = 1'b1; v[1] = 1'b1; v[0] = 1'b1; end
            default: ;
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: tracks phase and cycles already spent showing an element.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_st  <= 0;
            m_cnt <= 0;
        end else begin
            case (m_st)
                0:  if (jogar) m_st <= 1;
                1:  m_st <= 2;
                2:  begin m_st <= 3; m_cnt <= 0; end
                3:  if (m_cnt == TA - 1) begin m_st <= 4; m_cnt <= 0; end
                    else m_cnt <= m_cnt + 1;
                4:  if (m_cnt == TP - 1) begin m_st <= enderecoIgualLimite ? 6 : 5; m_cnt <= 0; end
                    else m_cnt <= m_cnt + 1;
                5:  m_st <= 3;
                6:  m_st <= 7;
                7:  if (timeout) m_st <= 14; else if (jogada_feita) m_st <= 8;
                8:  m_st <= 9;
                9:  if (!igual) m_st <= 13;
                    else if (!enderecoIgualLimite) m_st <= 10;
                    else if (fim_jogo) m_st <= 12;
                    else m_st <= 11;
                10: m_st <= 7;
                11: m_st <= 2;
                default: if (jogar) m_st <= 1;
            endcase
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clock) begin
        chk("model_state", int'(db_estado), m_st);
        chk("model_outputs", int'(w_dut), int'(exp_out(m_st)));
        if (conta_endereco) ce_cnt++;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_st(input int s, input int maxc);
        int n;
        n = 0;
        while (int'(db_estado) != s && n < maxc) begin
            tick();
            n++;
        end
        chk("wait_state", int'(db_estado), s);
    endtask

    task automatic restart;
        jogar = 1'b1;
        tick();
        jogar = 1'b0;
        chk("restart_prepara", int'(db_estado), 1);
        wait_st(7, 40);
    endtask

    initial begin
        int n;
        reset = 1'b0; jogar = 1'b0; igual = 1'b0; enderecoIgualLimite = 1'b0;
        fim_jogo = 1'b0; jogada_feita = 1'b0; timeout = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_estado", int'(db_estado), 0);
        chk("rst_zera_modo", int'(zera_modo), 1);
        chk("rst_conf_leds", int'(conf_leds), 1);
        reset = 1'b1;
        @(negedge clock);

        // Start: 1, 2, 3 on successive edges; round 0 playback.
        jogar = 1'b1;
        tick(); chk("start_1", int'(db_estado), 1);
        jogar = 1'b0;
        enderecoIgualLimite = 1'b1;
        tick(); chk("start_2", int'(db_estado), 2);
        tick(); chk("start_3", int'(db_estado), 3);
        // Press during playback must be ignored.
        jogada_feita = 1'b1;
        n = 0;
        while (db_estado == 4'd3 && n < 20) begin
            chk("aceso_leds_off", int'(conf_leds), 0);
            n++;
            tick();
            jogada_feita = 1'b0;
        end
        chk("aceso_cycles", n, TA);
        n = 0;
        while (db_estado == 4'd4 && n < 20) begin n++; tick(); end
        chk("apagado_cycles", n, TP);
        chk("fim_mostra", int'(db_estado), 6);
        tick(); chk("espera", int'(db_estado), 7);

        // Correct press, not last position.
        igual = 1'b1; enderecoIgualLimite = 1'b0; jogada_feita = 1'b1; ce_cnt = 0;
        tick(); jogada_feita = 1'b0; chk("registra", int'(db_estado), 8);
        tick(); chk("compara", int'(db_estado), 9);
        tick(); chk("prox_jogada", int'(db_estado), 10);
        tick(); chk("back_espera", int'(db_estado), 7);
        @(negedge clock); #1;
        chk("conta_endereco_pulses", ce_cnt, 1);

        // Last position, not last round: next round.
        enderecoIgualLimite = 1'b1; fim_jogo = 1'b0; jogada_feita = 1'b1;
        tick(); jogada_feita = 1'b0; chk("registra2", int'(db_estado), 8);
        tick(); chk("compara2", int'(db_estado), 9);
        tick(); chk("prox_rodada", int'(db_estado), 11);
        chk("conta_limite", int'(conta_limite), 1);
        tick(); chk("inicio_rodada", int'(db_estado), 2);
        chk("conta_limite_once", int'(conta_limite), 0);
        wait_st(7, 40);

        // Wrong press.
        igual = 1'b0; jogada_feita = 1'b1;
        tick(); jogada_feita = 1'b0;
        tick(); tick(); chk("fim_erro", int'(db_estado), 13);
        chk("erro_perdeu", int'(perdeu), 1);
        chk("erro_pronto", int'(pronto), 1);
        restart();

        // Timeout beats a simultaneous press.
        timeout = 1'b1; jogada_feita = 1'b1;
        tick(); timeout = 1'b0; jogada_feita = 1'b0;
        chk("fim_timeout", int'(db_estado), 14);
        chk("db_timeout", int'(db_timeout), 1);
        restart();

        // Win.
        igual = 1'b1; enderecoIgualLimite = 1'b1; fim_jogo = 1'b1; jogada_feita = 1'b1;
        tick(); jogada_feita = 1'b0;
        tick(); tick(); chk("fim_acerto", int'(db_estado), 12);
        chk("ganhou", int'(ganhou), 1);
        restart();

        // Async reset mid-ESPERA, no clock edge needed.
        @(negedge clock); #2;
        reset = 1'b0;
        #1;
        chk("async_rst_estado", int'(db_estado), 0);
        chk("async_rst_zera_modo", int'(zera_modo), 1);
        chk("async_rst_pronto", int'(pronto), 0);
        @(negedge clock);
        reset = 1'b1;
        jogar = 1'b1;
        tick(); chk("rerun_1", int'(db_estado), 1);
        jogar = 1'b0;
        tick(); chk("rerun_2", int'(db_estado), 2);
        tick(); chk("rerun_3", int'(db_estado), 3);
        @(negedge clock); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
